// File: rtl/inst_encoder.sv
// inst_encoder: field-bundle to RV32 instruction encoder feeding a 4-entry in-order FIFO.
// Optional illegal-bundle checking is enabled by defining ENC_ILLEGAL_CHECK_EN.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module inst_encoder (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [6:0]                 in_type,
    input  logic [`REG_ADDR_WIDTH-1:0] in_rd,
    input  logic [`REG_ADDR_WIDTH-1:0] in_rs1,
    input  logic [`REG_ADDR_WIDTH-1:0] in_rs2,
    input  logic [2:0]                 in_funct3,
    input  logic [6:0]                 in_funct7,
    input  logic [31:0]                in_imm,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [`INST_WIDTH-1:0]     out_instr,
    output logic [2:0]                 fifo_count,
    output logic                       enc_err
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic [31:0] enc;
    logic [31:0] mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic        accept, push, pop, illegal;

    always_comb begin
        enc = NOP;
        case (in_type)
            OP_R:      enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_type};
            // shift-immediates carry funct7 in the upper immediate bits
            OP_I:      enc = {(in_funct3[1:0] == 2'b01) ? in_funct7 : in_imm[11:5], in_imm[4:0],
                              in_rs1, in_funct3, in_rd, in_type};
            OP_LOAD, OP_JALR, OP_SYSTEM:
                       enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_type};
            OP_STORE:  enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_type};
            OP_BRANCH: enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                              in_imm[4:1], in_imm[11], in_type};
            OP_LUI, OP_AUIPC:
                       enc = {in_imm[31:12], in_rd, in_type};
            OP_JAL:    enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_type};
            default:   enc = NOP;
        endcase
    end

`ifdef ENC_ILLEGAL_CHECK_EN
    logic known;
    assign known   = in_type inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI,
                                     OP_JAL, OP_JALR, OP_AUIPC, OP_SYSTEM};
    assign illegal = !known || ((in_type == OP_BRANCH || in_type == OP_JAL) && in_imm[0]);

    always_ff @(posedge clk) begin
        if (reset)
            enc_err <= 1'b0;
        else
            enc_err <= accept && illegal;
    end
`else
    logic unused_imm0;
    assign unused_imm0 = in_imm[0];
    assign illegal     = 1'b0;
    assign enc_err     = 1'b0;
`endif

    assign in_ready  = !fifo_count[2];
    assign out_valid = fifo_count != 3'd0;
    assign out_instr = mem[rd_ptr];
    assign accept    = in_valid && in_ready;
    assign push      = accept && !illegal;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            fifo_count <= 3'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= enc;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            fifo_count <= fifo_count + 3'(push) - 3'(pop);
        end
    end
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed self-checking bench for inst_encoder.
module tb_inst_encoder;
    logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, enc_err;
    logic [6:0]  in_type = '0, in_funct7 = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]  in_funct3 = '0, fifo_count;
    logic [31:0] in_imm = '0, out_instr;
    int          checks = 0, passes = 0, fails = 0;
    int          q[$];

    inst_encoder dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_type(in_type), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .fifo_count(fifo_count), .enc_err(enc_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] t, input logic [4:0] rd, rs1, rs2,
                         input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
        in_type = t; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
    endtask

    // addi x0, x0, n
    function automatic logic [31:0] ai(input int n);
        return (32'(n) << 20) | 32'h13;
    endfunction

    task automatic enc_check(input string tag, input logic [6:0] t, input logic [4:0] rd, rs1, rs2,
                             input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                             input logic [31:0] exp);
        out_ready = 1'b1;
        drive(t, rd, rs1, rs2, f3, f7, imm);
        step();
        in_valid = 1'b0;
        check({tag, "_instr"}, out_instr, exp);
        step();
        check({tag, "_drained"}, 32'(fifo_count), 32'd0);
    endtask

    initial begin
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_enc_err", 32'(enc_err), 32'd0);
        reset = 1'b0;
        step();

        enc_check("r_add",  7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3);
        enc_check("i_addi", 7'b0010011, 5'd1, 5'd0, 5'd9, 3'd0, 7'h55, 32'd5, 32'h00500093);
        enc_check("store",  7'b0100011, 5'd7, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 32'h0020A423);
        enc_check("jal",    7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h008000EF);
        enc_check("lui",    7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7);
        enc_check("beq",    7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 32'h00208463);
        enc_check("srai",   7'b0010011, 5'd1, 5'd2, 5'd0, 3'b101, 7'b0100000, 32'h00000FE3, 32'h40315093);
        enc_check("auipc",  7'b0010111, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE123, 32'hABCDE117);
        enc_check("lw_neg", 7'b0000011, 5'd5, 5'd1, 5'd0, 3'b010, 7'd0, 32'hFFFFFFFC, 32'hFFC0A283);

`ifdef ENC_ILLEGAL_CHECK_EN
        out_ready = 1'b1;
        drive(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        step();
        in_valid = 1'b0;
        check("ill_br_err", 32'(enc_err), 32'd1);
        check("ill_br_nowrite", 32'(fifo_count), 32'd0);
        step();
        check("ill_br_err_pulse", 32'(enc_err), 32'd0);
        drive(7'b1111111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        step();
        in_valid = 1'b0;
        check("ill_unk_err", 32'(enc_err), 32'd1);
        check("ill_unk_nowrite", 32'(out_valid), 32'd0);
        step();
        check("ill_unk_err_pulse", 32'(enc_err), 32'd0);
`else
        enc_check("unk_nop", 7'b1111111, 5'd3, 5'd1, 5'd2, 3'd7, 7'h7F, 32'hFFFFFFFF, 32'h00000013);
        enc_check("br_odd", 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h00000163);
        check("no_enc_err", 32'(enc_err), 32'd0);
`endif

        // back-pressure: four fill the FIFO, the fifth waits for a pop
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'(i));
            step();
        end
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_count", 32'(fifo_count), 32'd4);
        check("full_head", out_instr, ai(1));
        drive(7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        step();
        check("full_hold_count", 32'(fifo_count), 32'd4);
        check("full_hold_head", out_instr, ai(1));
        out_ready = 1'b1;
        step();
        check("pop_count", 32'(fifo_count), 32'd3);
        check("pop_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check("fifth_count", 32'(fifo_count), 32'd4);
        out_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            check($sformatf("bp_order_%0d", i), out_instr, ai(i));
            step();
        end
        check("bp_empty", 32'(out_valid), 32'd0);

        // steady push+pop at depth 2 across pointer wrap
        out_ready = 1'b0;
        drive(7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd10);
        step();
        drive(7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd11);
        step();
        q = '{10, 11};
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'(12 + k));
            check($sformatf("wrap_head_%0d", k), out_instr, ai(q[0]));
            check($sformatf("wrap_count_%0d", k), 32'(fifo_count), 32'd2);
            step();
            void'(q.pop_front());
            q.push_back(12 + k);
        end
        in_valid = 1'b0;
        while (q.size() > 0) begin
            check("wrap_drain", out_instr, ai(q[0]));
            step();
            void'(q.pop_front());
        end
        check("wrap_empty", 32'(fifo_count), 32'd0);

        // reset mid-stream discards contents
        out_ready = 1'b0;
        for (int i = 20; i < 23; i++) begin
            drive(7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'(i));
            step();
        end
        in_valid = 1'b0;
        check("pre_rst_count", 32'(fifo_count), 32'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        step();
        check("post_rst_out_valid", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
